// File: rtl/spike_accum.sv
// Time-multiplexed synaptic integrator: scans one spike input per cycle and adds the matching weights
// into N_OUT parallel accumulators. Define SPIKE_ACCUM_SAT_EN for saturating adds (default: wrap-around).
module spike_accum #(
  parameter int W_WIDTH   = 16,
  parameter int N_IN      = 8,
  parameter int N_OUT     = 3,
  parameter int ACC_WIDTH = 20
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          wr_en,
  input  logic [$clog2(N_IN)-1:0]                       wr_in,
  input  logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0]  wr_out,
  input  logic [W_WIDTH-1:0]                            wr_data,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [N_IN-1:0]                               spikes,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [N_OUT*ACC_WIDTH-1:0]                    sums,
  output logic                                          busy
);

  localparam int IW = $clog2(N_IN);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e                        state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  logic [N_IN-1:0]               spk_q, spk_d;
  logic signed [ACC_WIDTH-1:0]   acc_q [N_OUT];
  logic signed [ACC_WIDTH-1:0]   acc_d [N_OUT];
  logic signed [W_WIDTH-1:0]     w_q   [N_IN][N_OUT];
  logic                          out_valid_q;
  logic                          last_idx;

  function automatic logic signed [ACC_WIDTH-1:0] acc_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [W_WIDTH-1:0]   w
  );
`ifdef SPIKE_ACCUM_SAT_EN
    logic signed [ACC_WIDTH:0] s;
    s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(w);
    // One guard bit: a disagreement between the top two bits means the add left the range.
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return s[ACC_WIDTH-1:0];
`else
    return a + ACC_WIDTH'(w);
`endif
  endfunction

  assign last_idx = (idx_q == IW'(N_IN-1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SCAN;
      SCAN:    if (last_idx)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = out_valid_q;
    sums      = '0;
    for (int unsigned k = 0; k < N_OUT; k++)
      sums[k*ACC_WIDTH +: ACC_WIDTH] = acc_q[k];
  end

  always_comb begin
    idx_d = idx_q;
    spk_d = spk_q;
    acc_d = acc_q;
    if (state_q == IDLE && in_valid) begin
      spk_d = spikes;
      idx_d = '0;
      for (int unsigned k = 0; k < N_OUT; k++) acc_d[k] = '0;
    end else if (state_q == SCAN) begin
      idx_d = last_idx ? '0 : idx_q + 1'b1;
      for (int unsigned k = 0; k < N_OUT; k++)
        acc_d[k] = acc_add(acc_q[k], spk_q[idx_q] ? w_q[idx_q][k] : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      spk_q       <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned k = 0; k < N_OUT; k++) acc_q[k] <= '0;
    end else begin
      idx_q       <= idx_d;
      spk_q       <= spk_d;
      out_valid_q <= (state_d == DONE);
      acc_q       <= acc_d;
    end
  end

  // Weight store: writes only in IDLE, out-of-range indices dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_IN; i++)
        for (int unsigned k = 0; k < N_OUT; k++)
          w_q[i][k] <= '0;
    end else if (state_q == IDLE && wr_en &&
                 int'(wr_in) < N_IN && int'(wr_out) < N_OUT) begin
      w_q[wr_in][wr_out] <= wr_data;
    end
  end

endmodule

// File: tb/tb_spike_accum.sv
// Randomized self-checking bench for spike_accum; checks a 20-bit and an 18-bit accumulator build side by side.
module tb_spike_accum;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wr_en, in_valid, out_ready;
  logic [2:0]  wr_in;
  logic [1:0]  wr_out;
  logic [15:0] wr_data;
  logic [7:0]  spikes;
  logic        in_ready, out_valid, busy;
  logic [59:0] sums;
  logic        in_ready_b, out_valid_b, busy_b;
  logic [53:0] sums_b;

  int n_cmp = 0;
  int n_bad = 0;
  int wm [8][3];

  spike_accum #(.W_WIDTH(16), .N_IN(8), .N_OUT(3), .ACC_WIDTH(20)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_in(wr_in), .wr_out(wr_out), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready), .spikes(spikes), .out_valid(out_valid),
    .out_ready(out_ready), .sums(sums), .busy(busy)
  );

  spike_accum #(.W_WIDTH(16), .N_IN(8), .N_OUT(3), .ACC_WIDTH(18)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_in(wr_in), .wr_out(wr_out), .wr_data(wr_data),
    .in_valid(in_valid), .in_ready(in_ready_b), .spikes(spikes), .out_valid(out_valid_b),
    .out_ready(out_ready), .sums(sums_b), .busy(busy_b)
  );

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer sum of selected weights, clamped per add or wrapped at the end.
  function automatic longint model_sum(input logic [7:0] spk, input int k, input int aw);
    longint one = 1;
    longint acc = 0;
    longint hi  = (one <<< (aw-1)) - 1;
    longint lo  = -(one <<< (aw-1));
    for (int j = 0; j < 8; j++) begin
      if (spk[j]) begin
        acc += wm[j][k];
`ifdef SPIKE_ACCUM_SAT_EN
        if (acc > hi) acc = hi;
        if (acc < lo) acc = lo;
`endif
      end
    end
`ifndef SPIKE_ACCUM_SAT_EN
    acc = acc & ((one <<< aw) - 1);
    if (acc > hi) acc -= (one <<< aw);
`endif
    return acc;
  endfunction

  function automatic longint sum_a(input int k);
    logic [19:0] s;
    s = sums[k*20 +: 20];
    return longint'($signed(s));
  endfunction

  function automatic longint sum_b(input int k);
    logic [17:0] s;
    s = sums_b[k*18 +: 18];
    return longint'($signed(s));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_sums(input string tag, input logic [7:0] spk);
    for (int k = 0; k < 3; k++) begin
      check_val({tag, "_acc20"}, sum_a(k), model_sum(spk, k, 20));
      check_val({tag, "_acc18"}, sum_b(k), model_sum(spk, k, 18));
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 3; k++)
        wm[i][k] = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    clear_model();
    check_val("reset_flags", {in_ready, out_valid, busy, in_ready_b, out_valid_b}, 5'b10010);
    check_sums("reset_sums", 8'h00);
  endtask

  task automatic write_w(input int i, input int k, input logic [15:0] d);
    wr_en = 1'b1; wr_in = 3'(i); wr_out = 2'(k); wr_data = d;
    tick();
    wr_en = 1'b0;
    if (k < 3) wm[i][k] = int'($signed(d));
  endtask

  // Entered and left at #1 after an edge with the DUT in IDLE, so calls chain back-to-back.
  task automatic run_txn(input logic [7:0] spk, input int hold, input bit do_wr,
                         input int wi, input int wk, input logic [15:0] wd);
    in_valid = 1'b1; spikes = spk; out_ready = 1'b0;
    if (do_wr) begin
      wr_en = 1'b1; wr_in = 3'(wi); wr_out = 2'(wk); wr_data = wd;
      if (wk < 3) wm[wi][wk] = int'($signed(wd));
    end
    tick();
    in_valid = 1'b0; wr_en = 1'b0; spikes = 8'($urandom);
    for (int c = 1; c <= 8; c++) begin
      check_val("scan_flags", {in_ready, out_valid, busy}, 3'b001);
      tick();
    end
    check_val("done_flags", {in_ready, out_valid, busy, out_valid_b}, 4'b0111);
    check_sums("done_sums", spk);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'($urandom); spikes = 8'hAA;
      wr_en = 1'b1; wr_in = 3'($urandom); wr_out = 2'($urandom_range(0, 2)); wr_data = 16'($urandom);
      tick();
      check_val("hold_valid", {out_valid, in_ready}, 2'b10);
      check_sums("hold_sums", spk);
    end
    in_valid = 1'b0; wr_en = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val("after_hs_flags", {in_ready, out_valid, busy, out_valid_b}, 4'b1000);
    check_sums("after_hs_sums", spk);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_in = '0; wr_out = '0; wr_data = '0;
    in_valid = 1'b0; spikes = '0; out_ready = 1'b0;
    do_reset();

    run_txn(8'hFF, 0, 1'b0, 0, 0, 16'h0);

    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 3; k++)
        write_w(i, k, 16'(i + 1));
    run_txn(8'b0000_0101, 0, 1'b0, 0, 0, 16'h0);
    run_txn(8'h80, 0, 1'b0, 0, 0, 16'h0);

    for (int i = 0; i < 8; i++) begin
      write_w(i, 0, 16'h8000);
      write_w(i, 1, 16'h7FFF);
      write_w(i, 2, 16'h7FFF);
    end
    run_txn(8'hFF, 0, 1'b0, 0, 0, 16'h0);

    run_txn(8'h5A, 5, 1'b0, 0, 0, 16'h0);
    run_txn(8'hFF, 0, 1'b1, 3, 2, 16'hC000);
    write_w(1, 3, 16'h1234);
    run_txn(8'h02, 0, 1'b0, 0, 0, 16'h0);

    for (int t = 0; t < 20; t++) begin
      int nw;
      nw = int'($urandom_range(0, 4));
      for (int n = 0; n < nw; n++)
        write_w(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 16'($urandom));
      run_txn(8'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 16'($urandom));
    end

    in_valid = 1'b1; spikes = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    check_val("midscan_rst_flags", {in_ready, out_valid, busy, out_valid_b}, 4'b1000);
    check_sums("midscan_rst_sums", 8'h00);
    run_txn(8'hFF, 0, 1'b0, 0, 0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
